// File: rtl/order_tx_framer.sv
// Order framer: buffers 128-bit orders from the CDC stage and serialises each one
// into a 6-beat 32-bit frame (header, four payload beats, checksum trailer).
module order_tx_framer #(
    parameter int BUF_DEPTH = 4
) (
    input  logic         core_clk,
    input  logic         reset,
    input  logic [127:0] tx_data,
    input  logic         tx_valid,
    output logic [31:0]  m_data,
    output logic         m_valid,
    input  logic         m_ready,
    output logic         m_last,
    output logic [15:0]  frame_count,
    output logic [15:0]  drop_count,
    output logic         busy
);

    localparam int PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int CW = PW + 1;

    localparam logic [7:0]  SYNC_BYTE = 8'hA5;
    localparam logic [7:0]  LEN_BYTE  = 8'h04;
    localparam logic [15:0] TRL_TAG   = 16'hC3C3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
        PAY  = 2'd2,
        TRL  = 2'd3
    } state_e;

    state_e          state_q, state_d;
    logic [1:0]      beat_q, beat_d;
    logic [15:0]     seq_q, seq_d;
    logic [127:0]    frame_q, frame_d;
    logic [15:0]     chk_q, chk_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [15:0]     frame_count_q, frame_count_d;
    logic [15:0]     drop_count_q, drop_count_d;
    logic [31:0]     m_data_q, m_data_d;
    logic            m_valid_q, m_valid_d;
    logic            m_last_q, m_last_d;

    logic [127:0]    mem [BUF_DEPTH];

    logic            hs;
    logic            buf_empty;
    logic            push;
    logic            pop;
    logic            drop;
    logic [127:0]    head;

    function automatic logic [15:0] fold16(input logic [127:0] d);
        logic [15:0] acc;
        acc = '0;
        for (int i = 0; i < 8; i++) begin
            acc = acc ^ d[i*16 +: 16];
        end
        return acc;
    endfunction

    assign hs        = m_valid_q && m_ready;
    assign buf_empty = (count_q == '0);
    // Full is judged on pre-edge occupancy, so a same-cycle pop cannot rescue a write.
    assign push      = tx_valid && (count_q < CW'(BUF_DEPTH));
    assign drop      = tx_valid && !push;
    assign head      = mem[rd_ptr_q];

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        state_d       = state_q;
        beat_d        = beat_q;
        seq_d         = seq_q;
        frame_count_d = frame_count_q;
        pop           = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (!buf_empty) begin
                    pop     = 1'b1;
                    state_d = HDR;
                end
            end
            HDR: begin
                if (hs) begin
                    state_d = PAY;
                    beat_d  = 2'd0;
                end
            end
            PAY: begin
                if (hs) begin
                    if (beat_q == 2'd3) begin
                        state_d = TRL;
                    end else begin
                        beat_d = beat_q + 2'd1;
                    end
                end
            end
            TRL: begin
                if (hs) begin
                    seq_d         = seq_q + 16'd1;
                    frame_count_d = frame_count_q + 16'd1;
                    if (!buf_empty) begin
                        pop     = 1'b1;
                        state_d = HDR;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Checksum uses the sequence number the loaded frame will carry, i.e. seq_d.
    always_comb begin
        frame_d  = frame_q;
        chk_d    = chk_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        if (pop) begin
            frame_d  = head;
            chk_d    = fold16(head) ^ seq_d;
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        if (push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end

        unique case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        drop_count_d = drop_count_q;
        if (drop && (drop_count_q != 16'hFFFF)) begin
            drop_count_d = drop_count_q + 16'd1;
        end
    end

    // Outputs are registered from next-state values, so they hold while stalled.
    always_comb begin
        m_data_d  = '0;
        m_valid_d = (state_d != IDLE);
        m_last_d  = (state_d == TRL);
        unique case (state_d)
            HDR: m_data_d = {SYNC_BYTE, LEN_BYTE, seq_d};
            PAY: begin
                unique case (beat_d)
                    2'd0:    m_data_d = frame_d[127:96];
                    2'd1:    m_data_d = frame_d[95:64];
                    2'd2:    m_data_d = frame_d[63:32];
                    default: m_data_d = frame_d[31:0];
                endcase
            end
            TRL:     m_data_d = {TRL_TAG, chk_d};
            default: m_data_d = '0;
        endcase
    end

    always_ff @(posedge core_clk or negedge reset) begin
        if (!reset) begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            state_q       <= IDLE;
            beat_q        <= 2'd0;
            seq_q         <= 16'd0;
            frame_q       <= '0;
            chk_q         <= 16'd0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            frame_count_q <= 16'd0;
            drop_count_q  <= 16'd0;
            m_data_q      <= 32'd0;
            m_valid_q     <= 1'b0;
            m_last_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            beat_q        <= beat_d;
            seq_q         <= seq_d;
            frame_q       <= frame_d;
            chk_q         <= chk_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            frame_count_q <= frame_count_d;
            drop_count_q  <= drop_count_d;
            m_data_q      <= m_data_d;
            m_valid_q     <= m_valid_d;
            m_last_q      <= m_last_d;
        end
    end

    // NOTE: buffer storage has no reset; occupancy and pointers alone decide what is valid.
    always_ff @(posedge core_clk) begin
        if (push) begin
            mem[wr_ptr_q] <= tx_data;
        end
    end

    assign m_data      = m_data_q;
    assign m_valid     = m_valid_q;
    assign m_last      = m_last_q;
    assign frame_count = frame_count_q;
    assign drop_count  = drop_count_q;
    assign busy        = (state_q != IDLE) || !buf_empty;

endmodule

// File: tb/tb_order_tx_framer.sv
// Scoreboard bench for order_tx_framer: stimulus queues expected beats, a monitor
// pops and compares on each output handshake and checks stability while stalled.
module tb_order_tx_framer;

    logic         core_clk = 1'b0;
    logic         reset    = 1'b0;
    logic [127:0] tx_data  = '0;
    logic         tx_valid = 1'b0;
    logic [31:0]  m_data;
    logic         m_valid;
    logic         m_ready  = 1'b1;
    logic         m_last;
    logic [15:0]  frame_count;
    logic [15:0]  drop_count;
    logic         busy;

    order_tx_framer #(.BUF_DEPTH(4)) dut (
        .core_clk    (core_clk),
        .reset       (reset),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .m_data      (m_data),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .m_last      (m_last),
        .frame_count (frame_count),
        .drop_count  (drop_count),
        .busy        (busy)
    );

    always #5 core_clk = ~core_clk;

    typedef struct packed {
        logic [31:0] data;
        logic        last;
    } beat_t;

    beat_t exp_q[$];
    int    tests = 0;
    int    fails = 0;
    logic  mon_en = 1'b1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge core_clk);
        #1;
    endtask

    task automatic exp_beat(input logic [31:0] d, input logic l);
        beat_t b;
        b.data = d;
        b.last = l;
        exp_q.push_back(b);
    endtask

    // Expected frame built from the frame format: halves folded by XOR, then XOR seq.
    task automatic exp_frame(input logic [127:0] d, input logic [15:0] s);
        logic [15:0] c;
        c = s;
        for (int i = 0; i < 8; i++) c = c ^ d[i*16 +: 16];
        exp_beat({8'hA5, 8'h04, s}, 1'b0);
        exp_beat(d[127:96], 1'b0);
        exp_beat(d[95:64], 1'b0);
        exp_beat(d[63:32], 1'b0);
        exp_beat(d[31:0], 1'b0);
        exp_beat({16'hC3C3, c}, 1'b1);
    endtask

    task automatic send(input logic [127:0] d);
        tx_data  = d;
        tx_valid = 1'b1;
        tick();
        tx_valid = 1'b0;
    endtask

    task automatic wait_frames(input logic [15:0] n);
        int k;
        k = 0;
        while (frame_count != n && k < 400) begin
            tick();
            k++;
        end
        check("frame_count", 32'(frame_count), 32'(n));
    endtask

    // Monitor: compare on handshake; while stalled, outputs must not move.
    logic        stall_prev = 1'b0;
    logic [31:0] prev_data;
    logic        prev_last;

    always @(negedge core_clk) begin
        beat_t e;
        if (!reset || !mon_en) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                check("stall_valid", 32'(m_valid), 32'd1);
                check("stall_data", m_data, prev_data);
                check("stall_last", 32'(m_last), 32'(prev_last));
            end
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_beat: got %h last %b with nothing expected", m_data, m_last);
                end else begin
                    e = exp_q.pop_front();
                    check("beat_data", m_data, e.data);
                    check("beat_last", 32'(m_last), 32'(e.last));
                end
            end
            stall_prev = m_valid && !m_ready;
            prev_data  = m_data;
            prev_last  = m_last;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        logic [127:0] ord;

        // Reset state
        #3;
        check("rst_m_valid", 32'(m_valid), 32'd0);
        check("rst_m_last", 32'(m_last), 32'd0);
        check("rst_m_data", m_data, 32'd0);
        check("rst_frame_count", 32'(frame_count), 32'd0);
        check("rst_drop_count", 32'(drop_count), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        tick();
        reset = 1'b1;
        tick();

        // Basic frame, first beat in cycle 2
        exp_beat(32'hA504_0000, 1'b0);
        exp_beat(32'h0000_0000, 1'b0);
        exp_beat(32'h0000_0000, 1'b0);
        exp_beat(32'h0000_0000, 1'b0);
        exp_beat(32'h0000_1234, 1'b0);
        exp_beat(32'hC3C3_1234, 1'b1);
        send({112'h0, 16'h1234});
        tick();
        check("latency_valid", 32'(m_valid), 32'd1);
        check("latency_hdr", m_data, 32'hA504_0000);
        wait_frames(16'd1);

        // Sequence increment
        exp_beat(32'hA504_0001, 1'b0);
        exp_beat(32'h0000_0000, 1'b0);
        exp_beat(32'h0000_0000, 1'b0);
        exp_beat(32'h0000_0000, 1'b0);
        exp_beat(32'h0000_1234, 1'b0);
        exp_beat(32'hC3C3_1235, 1'b1);
        send({112'h0, 16'h1234});
        wait_frames(16'd2);

        // Backpressure with ready pattern 1,0,0,1
        ord = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
        exp_frame(ord, 16'd2);
        send(ord);
        n = 0;
        while (frame_count != 16'd3 && n < 200) begin
            m_ready = (n % 4 == 0) || (n % 4 == 3);
            tick();
            n++;
        end
        m_ready = 1'b1;
        check("bp_frame_count", 32'(frame_count), 32'd3);
        check("bp_queue_empty", 32'(exp_q.size()), 32'd0);

        // Overflow: fresh reset, stalled output, 7 back-to-back orders
        tick();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        exp_q.delete();
        m_ready = 1'b0;
        for (int i = 0; i < 7; i++) begin
            ord = {32'hA000_0000 | 32'(i), 32'hB000_0000 | 32'(i),
                   32'hC000_0000 | 32'(i), 32'hD000_0000 | 32'(i)};
            if (i < 5) exp_frame(ord, 16'(i));
            tx_data  = ord;
            tx_valid = 1'b1;
            tick();
        end
        tx_valid = 1'b0;
        tick();
        tick();
        check("ovf_drop_count", 32'(drop_count), 32'd2);
        check("ovf_busy", 32'(busy), 32'd1);
        check("ovf_no_frames", 32'(frame_count), 32'd0);
        m_ready = 1'b1;
        n = 0;
        while (frame_count != 16'd5 && n < 200) begin
            tick();
            n++;
        end
        check("ovf_back_to_back_cycles", 32'(n), 32'd30);
        check("ovf_frame_count", 32'(frame_count), 32'd5);
        tick();
        check("ovf_idle_busy", 32'(busy), 32'd0);
        check("ovf_idle_m_data", m_data, 32'd0);

        // Sequence wrap
        force dut.seq_q = 16'hFFFF;
        tick();
        release dut.seq_q;
        exp_beat(32'hA504_FFFF, 1'b0);
        exp_beat(32'h0000_0000, 1'b0);
        exp_beat(32'h0000_0000, 1'b0);
        exp_beat(32'h0000_0000, 1'b0);
        exp_beat(32'h0000_0000, 1'b0);
        exp_beat(32'hC3C3_FFFF, 1'b1);
        exp_beat(32'hA504_0000, 1'b0);
        exp_beat(32'h0000_0000, 1'b0);
        exp_beat(32'h0000_0000, 1'b0);
        exp_beat(32'h0000_0000, 1'b0);
        exp_beat(32'h0000_0000, 1'b0);
        exp_beat(32'hC3C3_0000, 1'b1);
        send(128'h0);
        send(128'h0);
        wait_frames(16'd7);

        // Reset mid-frame during P1
        tick();
        mon_en = 1'b0;
        send(128'hDEAD_BEEF_CAFE_F00D_0123_4567_89AB_CDEF);
        tick();
        tick();
        tick();
        check("mid_in_p1", m_data, 32'hCAFE_F00D);
        reset = 1'b0;
        #1;
        check("mid_rst_valid", 32'(m_valid), 32'd0);
        check("mid_rst_last", 32'(m_last), 32'd0);
        check("mid_rst_data", m_data, 32'd0);
        check("mid_rst_frame_count", 32'(frame_count), 32'd0);
        check("mid_rst_drop_count", 32'(drop_count), 32'd0);
        tick();
        reset = 1'b1;
        exp_q.delete();
        mon_en = 1'b1;
        tick();
        exp_beat(32'hA504_0000, 1'b0);
        exp_beat(32'h0000_0000, 1'b0);
        exp_beat(32'h0000_0000, 1'b0);
        exp_beat(32'h0000_0000, 1'b0);
        exp_beat(32'h0000_00AA, 1'b0);
        exp_beat(32'hC3C3_00AA, 1'b1);
        send({120'h0, 8'hAA});
        wait_frames(16'd1);
        tick();
        check("final_queue_empty", 32'(exp_q.size()), 32'd0);
        check("final_busy", 32'(busy), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
